mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares one single-port synchronous RAM (registered read address, write on clock edge) between requester A and requester B. Each requester issues read/write beats over a valid/ready handshake. The arbiter muxes the winner onto the RAM port and returns tagged read data two cycles after acceptance. It sits directly in front of the RAM instance, with round-robin fairness and an optional bounded lock for back-to-back bursts.

## Interface
- addr_width, 6: RAM address width.
- bus_width, 14: RAM data width.
- max_burst, 4: maximum beats a locked requester may hold the port while the other side waits; range 1..15.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_a / valid_b  in  1  beat request.
- we_a / we_b  in  1  1 = write, 0 = read.
- lock_a / lock_b  in  1  requester wants the port for the next beat too.
- addr_a / addr_b  in  addr_width  beat address.
- wdata_a / wdata_b  in  bus_width  write data.
- ready_a / ready_b  out  1  beat accepted this cycle; combinational from state and valids.
- rvalid_a / rvalid_b  out  1  read data for that requester on rdata this cycle.
- rdata  out  bus_width  registered read data.
- mem_en  out  1  RAM write enable.
- mem_cs  out  1  RAM select; high on any accepted beat.
- mem_addr  out  addr_width  RAM address.
- mem_din  out  bus_width  RAM write data.
- mem_dout  in  bus_width  RAM read data; valid the cycle after its address was presented.

## Operation
- At most one beat is accepted per cycle. ready_a and ready_b are never high together.
- Accepted beat drives RAM combinationally:
  - mem_addr = addr_x, mem_din = wdata_x.
  - mem_en = we_x, mem_cs = 1.
- No grant: mem_en = 0, mem_cs = 0, mem_addr and mem_din = 0.
- FSM states: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant side selected by round-robin pointer rr (0 = A). After any grant in IDLE, rr flips to the loser's side.
  - Granted beat with lock_x = 1: go to LOCK_x, burst count bc = 1.
- LOCK_x:
  - Only x can be granted.
  - Each grant increments bc.
  - Return to IDLE after a grant with lock_x = 0.
  - Return to IDLE when valid_x = 0 for a cycle.
  - Forced exit: bc = max_burst and the other side is valid. No grant to x that cycle; next state IDLE, rr points to the other side.
  - Otherwise, while other side is idle, lock is held with bc saturating at max_burst.
- Read response pipeline, two stages carrying {valid, id}:
  - Stage 1 is set on an accepted read.
  - Stage 2 captures mem_dout into rdata and asserts rvalid_id.
- Writes produce no response.
- Read of an address written in an earlier cycle returns new data. Same-cycle read and write cannot occur (one beat per cycle).

## Timing
- Reset values: FSM IDLE, rr = 0, bc = 0, pipeline empty, rvalid_a/b = 0, rdata = 0. ready_a/b = 0 and mem_en/mem_cs = 0 while rst = 1.
- Read latency: beat accepted at edge N gives rvalid and rdata during cycle N+2, held exactly one cycle.
- Back-to-back reads stream one response per cycle, in acceptance order.
- Write takes effect at the acceptance edge.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after the reset edge. Lock state is cleared.
- Requester must hold valid, we, addr, wdata and lock stable until ready. The arbiter does not register request fields.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, LOCK_A, LOCK_B}.
  - requester id constants ID_A = 0, ID_B = 1.
  - width of bc (4 bits).
- Sub-module mem_rsp_pipe holds the two-stage {valid, id} tag pipeline plus the rdata capture register, with parameter bus_width.
- Top holds the FSM, rr, bc and the RAM muxes.

## Test plan
- Reset then single requester: A reads addr 5 after B writes 0x1234 to addr 5. Expected: rvalid_a = 1 with rdata = 0x1234 exactly 2 cycles after ready_a; rvalid_b is never high.
- Contention: A and B both valid with reads every cycle for 8 cycles, lock = 0. Expected: grants alternate A,B,A,B…, starting with A after reset; 8 responses in order with correct ids.
- Lock burst: A valid with lock = 1 for 6 beats, B valid throughout, max_burst = 4. Expected: A granted 4 consecutive beats, then one cycle with no grant, then B granted; afterwards A and B alternate.
- Lock release: A locked with B idle, then A drops lock on its 3rd beat while B becomes valid. Expected: FSM returns to IDLE and B is granted next cycle.
- Reset mid-read: A read accepted, rst asserted the next cycle. Expected: rvalid_a stays 0, rdata = 0, ready_a/b = 0 during reset.
- Write/read turnaround: B writes 0x3FFF to addr 63 then reads addr 63 on the next cycle. Expected: rdata = 0x3FFF, confirming address wrap and width limits.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   arb_state_t : arbitration FSM states (free, locked to A, locked to B)
//   ID_A / ID_B : requester tags carried through the read response pipeline
//   BC_W / bc_t : width and type of the burst counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int BC_W = 4;
  typedef logic [BC_W-1:0] bc_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Read response pipeline: two {valid, id} stages plus the rdata register.
//   clk, rst         : clock, synchronous active-high reset
//   acc_valid/acc_id : a read beat is accepted this cycle, and for whom
//   mem_dout         : RAM read data (valid one cycle after acceptance)
//   rvalid_a/b, rdata: tagged read response, two cycles after acceptance
module mem_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int bus_width = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_valid,
  input  logic                 acc_id,
  input  logic [bus_width-1:0] mem_dout,
  output logic                 rvalid_a,
  output logic                 rvalid_b,
  output logic [bus_width-1:0] rdata
);

  logic s1_v, s1_id;
  logic s2_v, s2_id;

  // Stage 1 lines up with the RAM registering the address; stage 2 lines
  // up with mem_dout being valid, so rdata is captured as stage 2 loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_id <= ID_A;
      s2_v  <= 1'b0;
      s2_id <= ID_A;
      rdata <= '0;
    end else begin
      s1_v  <= acc_valid;
      s1_id <= acc_id;
      s2_v  <= s1_v;
      s2_id <= s1_id;
      if (s1_v) begin
        rdata <= mem_dout;
      end
    end
  end

  assign rvalid_a = s2_v && (s2_id == ID_A);
  assign rvalid_b = s2_v && (s2_id == ID_B);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Handshake: a beat on side x transfers in any cycle where valid_x and
// ready_x are both high; the requester holds valid/we/lock/addr/wdata
// stable until ready_x. ready_x is combinational from FSM state and the
// valids, and at most one of ready_a/ready_b is high per cycle.
//   clk, rst                : clock, synchronous active-high reset
//   valid/we/lock/addr/wdata: per-requester beat request (suffix _a/_b)
//   ready_a/b               : beat accepted this cycle
//   rvalid_a/b, rdata       : read response, two cycles after acceptance
//   mem_en/cs/addr/din      : RAM port, driven combinationally by the winner
//   mem_dout                : RAM read data
//   dbg_state               : current arbitration FSM state
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addr_width = 6,
  parameter int bus_width  = 14,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_a,
  input  logic                  valid_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic                  lock_a,
  input  logic                  lock_b,
  input  logic [addr_width-1:0] addr_a,
  input  logic [addr_width-1:0] addr_b,
  input  logic [bus_width-1:0]  wdata_a,
  input  logic [bus_width-1:0]  wdata_b,
  output logic                  ready_a,
  output logic                  ready_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [bus_width-1:0]  rdata,
  output logic                  mem_en,
  output logic                  mem_cs,
  output logic [addr_width-1:0] mem_addr,
  output logic [bus_width-1:0]  mem_din,
  input  logic [bus_width-1:0]  mem_dout,
  output logic [1:0]            dbg_state
);

  localparam bc_t MAXB = bc_t'(max_burst);

  arb_state_t state_q, state_d;
  logic       rr_q, rr_d;      // side that wins a tie in IDLE
  bc_t        bc_q, bc_d;      // beats granted in the current lock
  logic       gnt_a, gnt_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= ID_A;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      bc_q    <= bc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    bc_d    = bc_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_a && (!valid_b || rr_q == ID_A)) begin
          gnt_a = 1'b1;
        end else if (valid_b) begin
          gnt_b = 1'b1;
        end
        // The loser (or the absent side) gets priority next time.
        if (gnt_a) begin
          rr_d = ID_B;
          if (lock_a) begin
            state_d = LOCK_A;
            bc_d    = bc_t'(1);
          end
        end
        if (gnt_b) begin
          rr_d = ID_A;
          if (lock_b) begin
            state_d = LOCK_B;
            bc_d    = bc_t'(1);
          end
        end
      end
      LOCK_A: begin
        if (bc_q == MAXB && valid_b) begin
          // Burst budget spent and B is waiting: idle cycle, B goes next.
          state_d = IDLE;
          rr_d    = ID_B;
          bc_d    = '0;
        end else if (valid_a) begin
          gnt_a = 1'b1;
          bc_d  = (bc_q < MAXB) ? bc_q + bc_t'(1) : bc_q;
          if (!lock_a) begin
            state_d = IDLE;
            bc_d    = '0;
          end
        end else begin
          state_d = IDLE;
          bc_d    = '0;
        end
      end
      LOCK_B: begin
        if (bc_q == MAXB && valid_a) begin
          state_d = IDLE;
          rr_d    = ID_A;
          bc_d    = '0;
        end else if (valid_b) begin
          gnt_b = 1'b1;
          bc_d  = (bc_q < MAXB) ? bc_q + bc_t'(1) : bc_q;
          if (!lock_b) begin
            state_d = IDLE;
            bc_d    = '0;
          end
        end else begin
          state_d = IDLE;
          bc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        bc_d    = '0;
      end
    endcase
    // Nothing is accepted while reset is held.
    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  assign ready_a   = gnt_a;
  assign ready_b   = gnt_b;
  assign dbg_state = state_q;

  assign mem_cs   = gnt_a | gnt_b;
  assign mem_en   = (gnt_a & we_a) | (gnt_b & we_b);
  assign mem_addr = gnt_a ? addr_a  : (gnt_b ? addr_b  : '0);
  assign mem_din  = gnt_a ? wdata_a : (gnt_b ? wdata_b : '0);

  mem_rsp_pipe #(
    .bus_width (bus_width)
  ) u_rsp (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (mem_cs & ~mem_en),
    .acc_id    (gnt_b ? ID_B : ID_A),
    .mem_dout  (mem_dout),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .rdata     (rdata)
  );

endmodule
